// File: rtl/dma_xfer_counter_if.sv
// rtl/dma_xfer_counter_if.sv - CPU byte-bus bundle for the DMA channel address/count registers
interface dma_xfer_counter_if;
    logic       wr;
    logic       rd;
    logic       sel;
    logic       clr_ff;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output wr, rd, sel, clr_ff, din,
        input  dout
    );

    modport slave (
        input  wr, rd, sel, clr_ff, din,
        output dout
    );
endinterface

// File: rtl/dma_xfer_counter.sv
// rtl/dma_xfer_counter.sv - DMA channel base/current address and word-count registers with terminal count
module dma_xfer_counter #(
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_xfer_counter_if.slave    bus,
    input  logic                 xfer,
    input  logic                 addr_dec,
    input  logic                 autoinit,
    output logic [AW-1:0]        cur_addr,
    output logic [AW-1:0]        cur_cnt,
    output logic                 armed,
    output logic                 tc,
    output logic                 done
);

    localparam int NB = AW / 8;
    localparam int FW = (NB > 1) ? $clog2(NB) : 1;

    logic [AW-1:0] base_addr;
    logic [AW-1:0] base_cnt;
    logic [FW-1:0] ff;
    logic [FW-1:0] ff_next;
    logic          ms_byte;

    logic [AW-1:0] base_addr_w;
    logic [AW-1:0] base_cnt_w;
    logic [AW-1:0] cur_addr_w;
    logic [AW-1:0] cur_cnt_w;
    logic [AW-1:0] addr_step;
    logic [7:0]    dout_b;

    assign ms_byte   = (ff == FW'(NB - 1));
    assign ff_next   = ms_byte ? '0 : ff + 1'b1;
    assign addr_step = addr_dec ? cur_addr - AW'(1) : cur_addr + AW'(1);
    assign bus.dout  = dout_b;

    // Byte-lane merge: the lane picked by ff is replaced with din in both register copies.
    always_comb begin
        base_addr_w = base_addr;
        base_cnt_w  = base_cnt;
        cur_addr_w  = cur_addr;
        cur_cnt_w   = cur_cnt;
        dout_b      = '0;
        for (int i = 0; i < NB; i++) begin
            if (ff == FW'(i)) begin
                base_addr_w[i*8 +: 8] = bus.din;
                base_cnt_w[i*8 +: 8]  = bus.din;
                cur_addr_w[i*8 +: 8]  = bus.din;
                cur_cnt_w[i*8 +: 8]   = bus.din;
                dout_b = bus.sel ? cur_cnt[i*8 +: 8] : cur_addr[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr <= '0;
            base_cnt  <= '0;
            cur_addr  <= '0;
            cur_cnt   <= '0;
            ff        <= '0;
            armed     <= 1'b0;
            tc        <= 1'b0;
            done      <= 1'b0;
        end else begin
            tc <= 1'b0;

            if (bus.clr_ff) begin
                ff <= '0;
            end else if (bus.wr || bus.rd) begin
                ff <= ff_next;
            end

            // A CPU write swallows any transfer strobe in the same cycle.
            if (bus.wr) begin
                if (bus.sel) begin
                    base_cnt <= base_cnt_w;
                    cur_cnt  <= cur_cnt_w;
                    if (ms_byte) begin
                        armed <= 1'b1;
                        done  <= 1'b0;
                    end
                end else begin
                    base_addr <= base_addr_w;
                    cur_addr  <= cur_addr_w;
                end
            end else if (xfer && armed) begin
                if (cur_cnt != '0) begin
                    cur_cnt  <= cur_cnt - AW'(1);
                    cur_addr <= addr_step;
                end else begin
                    tc <= 1'b1;
                    if (autoinit) begin
                        cur_addr <= base_addr;
                        cur_cnt  <= base_cnt;
                    end else begin
                        cur_cnt  <= '1;
                        cur_addr <= addr_step;
                        armed    <= 1'b0;
                        done     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_xfer_counter.sv
// tb/tb_dma_xfer_counter.sv - scoreboard bench for dma_xfer_counter with randomized traffic
module tb_dma_xfer_counter;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          xfer = 1'b0;
    logic          addr_dec = 1'b0;
    logic          autoinit = 1'b0;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] cur_cnt;
    logic          armed;
    logic          tc;
    logic          done;

    dma_xfer_counter_if bus ();

    dma_xfer_counter #(.AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .xfer     (xfer),
        .addr_dec (addr_dec),
        .autoinit (autoinit),
        .cur_addr (cur_addr),
        .cur_cnt  (cur_cnt),
        .armed    (armed),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_dout;
        logic [7:0]  dout;
        logic [15:0] addr;
        logic [15:0] cnt;
        bit          armed;
        bit          tc;
        bit          done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: registers held as plain integers, bytes handled by shifts and modulo.
    int unsigned m_base [2];
    int unsigned m_cur  [2];
    int          m_ff;
    bit          m_armed, m_tc, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_base[0] = 0; m_base[1] = 0; m_cur[0] = 0; m_cur[1] = 0;
        m_ff = 0; m_armed = 0; m_tc = 0; m_done = 0;
    endtask

    task automatic cycle(input bit w, input bit r, input bit s, input logic [7:0] d,
                         input bit c, input bit x, input bit dec, input bit ai);
        exp_t        e;
        int unsigned mask;
        @(negedge clk);
        bus.wr = w; bus.rd = r; bus.sel = s; bus.din = d; bus.clr_ff = c;
        xfer = x; addr_dec = dec; autoinit = ai;

        e.chk_dout = r && !w;
        e.dout     = 8'((m_cur[s] >> (8 * m_ff)) % 256);

        m_tc = 0;
        if (w) begin
            mask = 32'hff << (8 * m_ff);
            m_cur[s]  = (m_cur[s]  & ~mask) | (int'(d) << (8 * m_ff));
            m_base[s] = (m_base[s] & ~mask) | (int'(d) << (8 * m_ff));
            if (s && m_ff == 1) begin
                m_armed = 1;
                m_done  = 0;
            end
        end else if (x && m_armed) begin
            if (m_cur[1] == 0) m_tc = 1;
            if (m_cur[1] == 0 && ai) begin
                m_cur[0] = m_base[0];
                m_cur[1] = m_base[1];
            end else begin
                m_cur[1] = (m_cur[1] + 65535) % 65536;
                m_cur[0] = (m_cur[0] + (dec ? 65535 : 1)) % 65536;
                if (m_tc) begin
                    m_armed = 0;
                    m_done  = 1;
                end
            end
        end
        if (c)           m_ff = 0;
        else if (w || r) m_ff = 1 - m_ff;

        e.addr = 16'(m_cur[0]); e.cnt = 16'(m_cur[1]);
        e.armed = m_armed; e.tc = m_tc; e.done = m_done;
        q.push_back(e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic write16(input bit s, input logic [15:0] v);
        cycle(0, 0, 0, 8'h00, 1, 0, 0, 0);
        cycle(1, 0, s, v[7:0], 0, 0, 0, 0);
        cycle(1, 0, s, v[15:8], 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    // Monitor: dout sampled just before the edge, registered state just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk_dout) chk("dout", 32'(bus.dout), 32'(e.dout));
                @(posedge clk);
                #1;
                chk("cur_addr", 32'(cur_addr), 32'(e.addr));
                chk("cur_cnt",  32'(cur_cnt),  32'(e.cnt));
                chk("armed",    32'(armed),    32'(e.armed));
                chk("tc",       32'(tc),       32'(e.tc));
                chk("done",     32'(done),     32'(e.done));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        bit dec, ai;
        bus.wr = 0; bus.rd = 0; bus.sel = 0; bus.din = 0; bus.clr_ff = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_addr", 32'(cur_addr), 0);
        chk("rst_cnt",  32'(cur_cnt),  0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_done", 32'(done), 0);

        // Program 0x1234 / count 2, read address back, run past terminal count.
        write16(0, 16'h1234);
        write16(1, 16'h0002);
        cycle(0, 0, 0, 8'h00, 1, 0, 0, 0);
        cycle(0, 1, 0, 8'h00, 0, 0, 0, 0);
        cycle(0, 1, 0, 8'h00, 0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 8'h00, 0, 1, 0, 0);
        idle();
        drain();
        chk("s1_addr", 32'(cur_addr), 32'h1237);
        chk("s1_cnt",  32'(cur_cnt),  32'hffff);
        chk("s1_done", 32'(done), 1);

        // Autoinit with decrementing address: two full blocks.
        write16(0, 16'h0010);
        write16(1, 16'h0001);
        repeat (4) cycle(0, 0, 0, 8'h00, 0, 1, 1, 1);
        idle();
        drain();
        chk("s2_addr", 32'(cur_addr), 32'h0010);
        chk("s2_armed", 32'(armed), 1);

        // Address wrap on increment.
        write16(0, 16'hffff);
        write16(1, 16'h0005);
        cycle(0, 0, 0, 8'h00, 0, 1, 0, 0);
        idle();
        drain();
        chk("s3_addr", 32'(cur_addr), 32'h0000);
        chk("s3_cnt",  32'(cur_cnt),  32'h0004);

        // Write colliding with xfer at count 0, then clr_ff together with a write.
        write16(1, 16'h0000);
        cycle(0, 0, 0, 8'h00, 1, 0, 0, 0);
        cycle(1, 0, 1, 8'h07, 0, 1, 0, 0);
        cycle(1, 0, 1, 8'h00, 1, 0, 0, 0);
        cycle(0, 1, 1, 8'h00, 0, 0, 0, 0);
        idle();
        drain();

        // Randomized traffic with mostly small counts so terminal counts occur.
        dec = 0; ai = 0;
        for (int i = 0; i < 600; i++) begin
            bit w, r, c;
            logic [7:0] d;
            if (i % 50 == 0) begin
                dec = 1'($urandom_range(0, 1));
                ai  = 1'($urandom_range(0, 1));
            end
            w = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            cycle(w, r, 1'($urandom_range(0, 1)), d, c, 1'($urandom_range(0, 1)), dec, ai);
        end
        idle();
        drain();

        // Asynchronous reset mid-block.
        write16(0, 16'h4000);
        write16(1, 16'h0003);
        idle();
        drain();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr",  32'(cur_addr), 0);
        chk("arst_cnt",   32'(cur_cnt),  0);
        chk("arst_armed", 32'(armed), 0);
        chk("arst_done",  32'(done), 0);
        chk("arst_tc",    32'(tc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (5) cycle(0, 0, 0, 8'h00, 0, 1, 0, 0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_xfer_counter.md
Name: dma_xfer_counter

Overview:
- Per-channel current/base address and word-count register pair for the DMA channel datapath.
- Loaded by the CPU over an 8-bit bus through a byte-pointer flip-flop.
- Advances once per transfer strobe and generates the terminal-count event that ends or auto-reinitializes the channel.
- It is the producer of the address and word-count values that the terminal-count comparator consumes.

Parameters:
- AW, 16, width of address and word-count registers; must be a multiple of 8, minimum 16.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr  in  1  CPU write strobe, one byte per cycle
- rd  in  1  CPU read strobe, one byte per cycle
- sel  in  1  register select: 0 = address, 1 = word count
- din  in  8  CPU write data
- dout  out  8  CPU read data (combinational byte of the selected current register)
- clr_ff  in  1  clear byte-pointer flip-flop
- xfer  in  1  one completed transfer cycle
- addr_dec  in  1  1 = address decrements per transfer, 0 = increments
- autoinit  in  1  reload current registers from base registers on terminal count
- cur_addr  out  AW  current address register
- cur_cnt  out  AW  current word-count register
- armed  out  1  channel may transfer
- tc  out  1  one-cycle terminal-count pulse
- done  out  1  sticky: terminal count reached with autoinit=0

Behaviour:
- Reset (async, rst_n=0): all base and current registers 0; byte pointer ff=0; armed=0; tc=0; done=0.
- Byte pointer ff:
  - ff=0 selects bits [7:0]; ff=1 selects bits [15:8].
  - For AW>16, upper bytes are loaded only through a sequence of writes that extends ff to a byte index modulo AW/8.
  - Every wr or rd toggles/advances ff.
  - clr_ff forces ff=0 and takes priority over the advance in the same cycle.
  - A wr and rd in the same cycle is illegal; wr wins and rd is ignored.
- CPU write:
  - Writes din into the selected byte of both the base and current register chosen by sel.
  - A write to the most-significant count byte sets armed=1 and clears done.
- CPU read:
  - dout = selected byte of the current register chosen by sel, indexed by ff.
  - dout is valid in the same cycle rd is asserted; ff advances at the clock edge.
- Transfer, xfer=1 with armed=1 and no wr that cycle:
  - If cur_cnt != 0: cur_cnt decrements by 1; cur_addr changes by ±1 modulo 2^AW per addr_dec; tc=0 next cycle.
  - If cur_cnt == 0 (terminal count): tc=1 for exactly the next cycle.
    - With autoinit=1: cur_addr and cur_cnt are reloaded from the base registers; armed stays 1; done unchanged.
    - With autoinit=0: cur_cnt wraps to all-ones; cur_addr steps by ±1 as normal; armed clears; done sets.
  - A programmed count N therefore yields N+1 transfers.
- Transfer while not armed: ignored; registers, tc and done unchanged.
- CPU write in the same cycle as xfer: the write is applied and the xfer is dropped entirely (no count or address step, no tc). The bus master guarantees this does not occur mid-block.
- Address wrap: FFFF+1 → 0000 and 0000−1 → FFFF. There is no carry into the count and no tc from address wrap.
- Reset asserted mid-block clears everything immediately. tc is not generated for the aborted block.
- Outputs cur_addr, cur_cnt, armed, tc and done are all registered.

Test Plan:
- Reset, then clr_ff; write addr bytes 0x34, 0x12; write count bytes 0x02, 0x00 → cur_addr=0x1234, cur_cnt=0x0002, armed=1, dout reads back 0x34 then 0x12.
- From that state with addr_dec=0, autoinit=0, apply 3 xfer → cur_addr steps 0x1235, 0x1236, 0x1237; cur_cnt steps 1, 0, 0xFFFF. tc pulses one cycle after the 3rd xfer; done=1, armed=0. A 4th xfer leaves all state unchanged.
- autoinit=1, base addr 0x0010, count 0x0001, addr_dec=1: 2 xfer → tc pulse; cur_addr=0x0010 and cur_cnt=0x0001 reloaded; armed=1; done=0. A further 2 xfer give a second tc.
- Address wrap: addr 0xFFFF, count 0x0005, addr_dec=0, 1 xfer → cur_addr=0x0000, cur_cnt=0x0004, tc=0.
- Same-cycle wr and xfer on an armed channel with count 0 → no tc, count byte written, no decrement. clr_ff with wr in the same cycle → ff=0 afterwards.
- Assert rst_n=0 asynchronously between clock edges mid-block (cur_cnt=0x0003) → all outputs 0 immediately, no tc after release.
